serial_tx: RTL and testbench



---
 rtl/serial_pkg.sv | 24 ++
 rtl/serial_tx_if.sv | 18 +
 rtl/serial_tx.sv | 100 ++++++++++
 tb/tb_serial_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial_tx / serial_rx framing.
package serial_pkg;

    localparam int SER_DATA_W  = 256;
    localparam int SER_CNT_W   = 32;
    localparam int SER_NBITS_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEAD = 2'd1,
        ST_BIT  = 2'd2
    } ser_state_t;

    // A zero count or period would never match a target, so it means 1.
    function automatic logic [SER_CNT_W-1:0] sat1(input logic [SER_CNT_W-1:0] v);
        return (v == '0) ? SER_CNT_W'(1) : v;
    endfunction

    // Same substitution for the bit count.
    function automatic logic [SER_NBITS_W-1:0] sat1_nb(input logic [SER_NBITS_W-1:0] v);
        return (v == '0) ? SER_NBITS_W'(1) : v;
    endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Control, framing and line signals of the serial transmitter.
interface serial_tx_if;
    import serial_pkg::*;

    logic                   start;
    logic [SER_DATA_W-1:0]  data;
    logic [SER_NBITS_W-1:0] nbits;
    logic [SER_CNT_W-1:0]   n0;
    logic [SER_CNT_W-1:0]   n1;
    logic [SER_CNT_W-1:0]   cnt;
    logic                   y;
    logic                   busy;
    logic                   done;

    modport master (output start, data, nbits, n0, n1, cnt, input y, busy, done);
    modport slave  (input start, data, nbits, n0, n1, cnt, output y, busy, done);

endinterface

// File: rtl/serial_tx.sv
// MSB-first serial transmitter paced by the shared cnt timebase.
module serial_tx
    import serial_pkg::*;
#(
    parameter logic P_Y_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_tx_if.slave  bus
);

    localparam logic [8:0] SH_FULL = 9'(SER_DATA_W);

    ser_state_t             state_q;
    logic [SER_DATA_W-1:0]  sr_q;
    logic [SER_NBITS_W-1:0] nb_q;
    logic [SER_CNT_W-1:0]   n1_q;
    logic [SER_CNT_W-1:0]   t_q;
    logic [8:0]             k_q;
    logic                   y_q;
    logic                   busy_q;
    logic                   done_q;

    logic [SER_NBITS_W-1:0] nb_in;
    logic [8:0]             sh_amt;
    logic                   hit;

    assign nb_in  = sat1_nb(bus.nbits);
    // Left-align the word so the first bit to send lands in sr_q[255].
    assign sh_amt = SH_FULL - {1'b0, nb_in};
    assign hit    = (bus.cnt == t_q);

    // Frame FSM: lead-in, then nb bit periods, each ending on a cnt target match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            // NOTE: the wide shift register is reset along with the control
            // state so a frame aborted mid-way leaves no stale bits behind.
            sr_q    <= '0;
            nb_q    <= '0;
            n1_q    <= '0;
            t_q     <= '0;
            k_q     <= '0;
            y_q     <= P_Y_INIT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: all state is updated with non-blocking assignments so every
            // branch below sees the values from before this edge.
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    y_q <= P_Y_INIT;
                    if (bus.start) begin
                        sr_q    <= bus.data << sh_amt;
                        nb_q    <= nb_in;
                        n1_q    <= sat1(bus.n1);
                        t_q     <= bus.cnt + sat1(bus.n0);
                        busy_q  <= 1'b1;
                        state_q <= ST_LEAD;
                    end
                end
                ST_LEAD: begin
                    if (hit) begin
                        y_q     <= sr_q[SER_DATA_W-1];
                        sr_q    <= sr_q << 1;
                        t_q     <= bus.cnt + n1_q;
                        k_q     <= 9'd1;
                        state_q <= ST_BIT;
                    end
                end
                ST_BIT: begin
                    if (hit) begin
                        if (k_q < {1'b0, nb_q}) begin
                            y_q  <= sr_q[SER_DATA_W-1];
                            sr_q <= sr_q << 1;
                            t_q  <= bus.cnt + n1_q;
                            k_q  <= k_q + 9'd1;
                        end else begin
                            y_q     <= P_Y_INIT;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    y_q     <= P_Y_INIT;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.y    = y_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: stimulus queues expected frames, a monitor
// checks the line cycle by cycle and rebuilds the received word.
module tb_serial_tx;
    import serial_pkg::*;

    localparam logic Y_INIT = 1'b1;

    typedef struct {
        logic [SER_DATA_W-1:0] data;
        int                    nb;
        logic [31:0]           n0;
        logic [31:0]           n1;
        logic [31:0]           c;
        logic [31:0]           done_m;
    } exp_t;

    logic clk         = 1'b0;
    logic rst_n       = 1'b0;
    logic end_of_test = 1'b0;

    exp_t exp_q[$];
    int   errors     = 0;
    int   checks     = 0;
    int   done_count = 0;

    exp_t             cur;
    logic             active   = 1'b0;
    logic             in_reset = 1'b0;
    logic [255:0]     rx_word  = '0;
    logic [31:0]      m, d, e, i_idx, ph;
    logic             ey, eb, ed;

    serial_tx_if bus ();

    serial_tx #(.P_Y_INIT(Y_INIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: samples on the falling edge; m is the cnt value the DUT saw on the last rising edge.
    initial begin : monitor
        forever begin
            @(negedge clk or negedge rst_n or posedge end_of_test);
            if (end_of_test) begin
                check("queue_empty", 256'(exp_q.size()), 256'd0);
                check("frame_idle", 256'(active), 256'd0);
                check("done_count", 256'(done_count), 256'd6);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end else if (!rst_n) begin
                if (!in_reset) begin
                    in_reset = 1'b1;
                    #1;
                    check("rst_y", 256'(bus.y), 256'(Y_INIT));
                    check("rst_busy", 256'(bus.busy), 256'd0);
                    check("rst_done", 256'(bus.done), 256'd0);
                    active = 1'b0;
                end
            end else begin
                in_reset = 1'b0;
                m = bus.cnt - 32'd1;
                if (!active && bus.busy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_busy", 256'(bus.busy), 256'd0);
                    end else begin
                        cur     = exp_q.pop_front();
                        active  = 1'b1;
                        rx_word = '0;
                    end
                end
                if (active) begin
                    d  = m - cur.c;
                    ey = Y_INIT;
                    eb = 1'b1;
                    ed = 1'b0;
                    if (d >= cur.n0) begin
                        e     = d - cur.n0;
                        i_idx = e / cur.n1;
                        ph    = e % cur.n1;
                        if (i_idx < 32'(cur.nb)) begin
                            ey = cur.data[32'(cur.nb) - 32'd1 - i_idx];
                            if (ph == cur.n1 / 32'd2)
                                rx_word[32'(cur.nb) - 32'd1 - i_idx] = bus.y;
                        end else begin
                            eb = 1'b0;
                            ed = 1'b1;
                        end
                    end
                    check("line_y", 256'(bus.y), 256'(ey));
                    check("busy", 256'(bus.busy), 256'(eb));
                    check("done", 256'(bus.done), 256'(ed));
                    if (bus.done) begin
                        check("done_cnt", 256'(m), 256'(cur.done_m));
                        check("rx_word", rx_word, cur.data & ((256'd1 << cur.nb) - 256'd1));
                        done_count++;
                        active = 1'b0;
                    end
                end else begin
                    check("idle_y", 256'(bus.y), 256'(Y_INIT));
                    check("stray_done", 256'(bus.done), 256'd0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.cnt   = bus.cnt + 32'd1;
    endtask

    task automatic steps(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    // Present one start with its framing and queue the hand-computed expectation.
    task automatic launch(input logic [255:0] dat, input logic [7:0] nbits,
                          input logic [31:0] n0, input logic [31:0] n1, input logic [31:0] c,
                          input int e_nb, input logic [31:0] e_n0, input logic [31:0] e_n1,
                          input logic [31:0] e_done);
        exp_t r;
        bus.data  = dat;
        bus.nbits = nbits;
        bus.n0    = n0;
        bus.n1    = n1;
        bus.cnt   = c;
        bus.start = 1'b1;
        r.data    = dat;
        r.nb      = e_nb;
        r.n0      = e_n0;
        r.n1      = e_n1;
        r.c       = c;
        r.done_m  = e_done;
        exp_q.push_back(r);
        step();
    endtask

    initial begin : stim
        logic [255:0] rnd;
        bus.start = 1'b0;
        bus.data  = '0;
        bus.nbits = '0;
        bus.n0    = '0;
        bus.n1    = '0;
        bus.cnt   = '0;
        steps(3);
        @(posedge clk);
        #3 rst_n = 1'b1;
        steps(2);

        // Basic frame 0xA5: lead to 14, eight 2-count bits, done at 30.
        launch(256'hA5, 8'd8, 32'd4, 32'd2, 32'd10, 8, 32'd4, 32'd2, 32'd30);
        for (int j = 0; j < 100 && bus.cnt != 32'd30; j++) step();
        // start on the done edge is ignored (still in BIT).
        bus.start = 1'b1;
        step();
        steps(5);

        // All-zero framing: one 1-count bit; upper data bits must be discarded.
        launch(256'h8001, 8'd0, 32'd0, 32'd0, 32'd100, 1, 32'd1, 32'd1, 32'd102);
        steps(8);

        // Targets wrap past 2^32: bits at cnt 1..4, done at 5.
        launch(256'h9, 8'd4, 32'd3, 32'd1, 32'hFFFF_FFFE, 4, 32'd3, 32'd1, 32'd5);
        steps(12);

        // 200-bit random word rebuilt by the monitor's mid-bit sampler.
        rnd = '0;
        for (int j = 0; j < 8; j++) rnd = {rnd[223:0], 32'($urandom)};
        launch(rnd, 8'd200, 32'd5, 32'd3, 32'd1000, 200, 32'd5, 32'd3, 32'd1605);
        steps(620);

        // Second start mid-frame with new inputs must not disturb the frame.
        launch(256'h3C, 8'd6, 32'd2, 32'd4, 32'd5000, 6, 32'd2, 32'd4, 32'd5026);
        steps(10);
        bus.data  = 256'hFF;
        bus.nbits = 8'd3;
        bus.n0    = 32'd1;
        bus.n1    = 32'd1;
        bus.start = 1'b1;
        step();
        steps(25);

        // Reset during BIT, then a clean frame.
        launch(256'h5A, 8'd8, 32'd2, 32'd3, 32'd200, 8, 32'd2, 32'd3, 32'd226);
        steps(8);
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        steps(2);
        launch(256'hC3, 8'd8, 32'd1, 32'd1, 32'd300, 8, 32'd1, 32'd1, 32'd309);
        steps(15);

        end_of_test = 1'b1;
    end

endmodule
